// File: rtl/pwm_multi_channel.sv
// rtl/pwm_multi_channel.sv - multi-channel PWM with shared period counter and shadowed duty/period
module pwm_multi_channel #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 reg_wr_en,
    input  logic                 reg_rd_en,
    input  logic [7:0]           reg_addr,
    input  logic [31:0]          reg_wdata,
    output logic [31:0]          reg_rdata,
    output logic                 reg_rvalid,
    output logic [NUM_CH-1:0]    pwm_out,
    output logic                 period_tick
);

    logic                 en, mode, dir;
    logic [CNT_WIDTH-1:0] period_sh, period_act, cnt;
    logic [NUM_CH-1:0]    pol;
    logic [CNT_WIDTH-1:0] duty_sh  [NUM_CH];
    logic [CNT_WIDTH-1:0] duty_act [NUM_CH];

    logic                 en_nx, mode_nx, dir_nx, boundary, load;
    logic [CNT_WIDTH-1:0] period_sh_nx, period_act_nx, cnt_nx;
    logic [NUM_CH-1:0]    pol_nx, pwm_nx;
    logic [CNT_WIDTH-1:0] duty_sh_nx  [NUM_CH];
    logic [CNT_WIDTH-1:0] duty_act_nx [NUM_CH];
    logic [31:0]          rdata_nx;
    logic [5:0]           word;
    logic                 unused_bits;

    assign word        = reg_addr[7:2];
    assign unused_bits = ^{reg_addr[1:0], reg_wdata};

    // Post-write register values; the counter and outputs are computed from these
    always_comb begin
        en_nx        = en;
        mode_nx      = mode;
        period_sh_nx = period_sh;
        pol_nx       = pol;
        duty_sh_nx   = duty_sh;
        if (reg_wr_en) begin
            case (word)
                6'd0: begin
                    en_nx   = reg_wdata[0];
                    mode_nx = reg_wdata[1];
                end
                6'd1:    period_sh_nx = reg_wdata[CNT_WIDTH-1:0];
                6'd3:    pol_nx       = reg_wdata[NUM_CH-1:0];
                default: ;
            endcase
            for (int i = 0; i < NUM_CH; i++) begin
                if (word == 6'(4 + i))
                    duty_sh_nx[i] = reg_wdata[CNT_WIDTH-1:0];
            end
        end
    end

    // Counter step; an up-step that would pass P (incl. after a mode change) wraps as a boundary
    always_comb begin
        cnt_nx   = '0;
        dir_nx   = 1'b0;
        boundary = 1'b0;
        if (en && en_nx) begin
            if (!mode_nx || !dir) begin
                if (cnt >= period_act) begin
                    boundary = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                    dir_nx = mode_nx && (cnt_nx == period_act);
                end
            end else begin
                if (cnt <= CNT_WIDTH'(1)) begin
                    boundary = 1'b1;
                end else begin
                    cnt_nx = cnt - 1'b1;
                    dir_nx = 1'b1;
                end
            end
        end
    end

    always_comb begin
        load          = !en || !en_nx || boundary;
        period_act_nx = load ? period_sh_nx : period_act;
        pwm_nx        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            duty_act_nx[i] = load ? duty_sh_nx[i] : duty_act[i];
            if (en_nx)
                pwm_nx[i] = ((cnt_nx < duty_act_nx[i]) ||
                             (mode_nx && duty_act_nx[i] != '0 && duty_act_nx[i] >= period_act_nx))
                            ^ pol_nx[i];
            else
                pwm_nx[i] = pol_nx[i];
        end
    end

    // Read mux uses pre-write values
    always_comb begin
        rdata_nx = '0;
        case (word)
            6'd0: rdata_nx[1:0] = {mode, en};
            6'd1: rdata_nx[CNT_WIDTH-1:0] = period_sh;
            6'd2: begin
                rdata_nx[CNT_WIDTH-1:0] = cnt;
                rdata_nx[31]            = dir;
            end
            6'd3:    rdata_nx[NUM_CH-1:0] = pol;
            default: ;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (word == 6'(4 + i))
                rdata_nx[CNT_WIDTH-1:0] = duty_sh[i];
        end
        if (!reg_rd_en)
            rdata_nx = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            en          <= 1'b0;
            mode        <= 1'b0;
            dir         <= 1'b0;
            period_sh   <= '0;
            period_act  <= '0;
            cnt         <= '0;
            pol         <= '0;
            pwm_out     <= '0;
            period_tick <= 1'b0;
            reg_rdata   <= '0;
            reg_rvalid  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_sh[i]  <= '0;
                duty_act[i] <= '0;
            end
        end else begin
            en          <= en_nx;
            mode        <= mode_nx;
            dir         <= dir_nx;
            period_sh   <= period_sh_nx;
            period_act  <= period_act_nx;
            cnt         <= cnt_nx;
            pol         <= pol_nx;
            pwm_out     <= pwm_nx;
            period_tick <= boundary;
            reg_rdata   <= rdata_nx;
            reg_rvalid  <= reg_rd_en;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_sh[i]  <= duty_sh_nx[i];
                duty_act[i] <= duty_act_nx[i];
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb/tb_pwm_multi_channel.sv - scoreboard bench for pwm_multi_channel
module tb_pwm_multi_channel;
    localparam int NUM_CH    = 4;
    localparam int CNT_WIDTH = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              reg_wr_en = 1'b0;
    logic              reg_rd_en = 1'b0;
    logic [7:0]        reg_addr = '0;
    logic [31:0]       reg_wdata = '0;
    logic [31:0]       reg_rdata;
    logic              reg_rvalid;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_tick;

    always #5 clock = ~clock;

    pwm_multi_channel #(.NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .reg_wr_en   (reg_wr_en),
        .reg_rd_en   (reg_rd_en),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .reg_rvalid  (reg_rvalid),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    typedef struct packed {
        logic [15:0]       tag;
        logic [NUM_CH-1:0] pwm;
        logic              tick;
    } pwm_exp_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] val;
    } rd_exp_t;

    pwm_exp_t pwm_q[$];
    rd_exp_t  rd_q[$];
    pwm_exp_t pe;
    rd_exp_t  re;
    int       checks = 0;
    int       errors = 0;

    // Monitor: one pwm expectation per cycle while queued, one read expectation per rvalid
    always @(negedge clock) begin
        if (pwm_q.size() > 0) begin
            pe = pwm_q.pop_front();
            checks++;
            if (pwm_out !== pe.pwm || period_tick !== pe.tick) begin
                errors++;
                $display("FAIL pwm_step%0d pwm_out=%b tick=%b expected pwm_out=%b tick=%b",
                         pe.tag, pwm_out, period_tick, pe.pwm, pe.tick);
            end
        end
        if (reg_rvalid === 1'b1) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rvalid_unexpected rdata=%h expected no rvalid", reg_rdata);
            end else begin
                re = rd_q.pop_front();
                if (reg_rdata !== re.val) begin
                    errors++;
                    $display("FAIL read_addr_%h rdata=%h expected %h", re.addr, reg_rdata, re.val);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        reg_wr_en = 1'b0;
        reg_rd_en = 1'b0;
    endtask

    task automatic cyc(input logic [NUM_CH-1:0] p, input logic t, input int tag);
        pwm_q.push_back({16'(tag), p, t});
        step();
    endtask

    task automatic set_wr(input logic [7:0] a, input logic [31:0] d);
        reg_wr_en = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
    endtask

    task automatic set_rd(input logic [7:0] a, input logic [31:0] e);
        reg_rd_en = 1'b1;
        reg_addr  = a;
        rd_q.push_back({a, e});
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        set_wr(a, d);
        step();
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e);
        set_rd(a, e);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, d, cnt;
        step();
        step();
        reset = 1'b0;

        checks++;
        if (reg_rvalid !== 1'b0 || reg_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rd rvalid=%b rdata=%h expected 0 0", reg_rvalid, reg_rdata);
        end
        cyc(4'b0000, 1'b0, 0);
        rd(8'h00, 32'h0);
        rd(8'h04, 32'h0);
        rd(8'h08, 32'h0);
        rd(8'h0C, 32'h0);
        rd(8'h10, 32'h0);

        // Edge mode: P=9, duty0=3, duty2=0, duty3=10 with ch3 inverted
        wr(8'h04, 32'd9);
        wr(8'h10, 32'd3);
        wr(8'h18, 32'd0);
        wr(8'h1C, 32'd10);
        wr(8'h0C, 32'h8);
        cyc(4'b1000, 1'b0, 1);
        set_wr(8'h00, 32'h1);
        step();
        for (int k = 0; k < 45; k++) begin
            case (k)
                25: set_wr(8'h10, 32'd7);
                26: set_rd(8'h08, 32'd6);
                27: set_rd(8'h10, 32'd7);
                28: set_rd(8'h80, 32'h0);
                29: set_wr(8'h20, 32'h55);
                30: set_rd(8'h20, 32'h0);
                31: set_rd(8'h04, 32'd9);
                32: set_rd(8'h0C, 32'h8);
                44: set_wr(8'h00, 32'h0);
                default: ;
            endcase
            c = k % 10;
            d = (k < 30) ? 3 : 7;
            cyc({3'b000, c < d}, (k > 0) && (c == 0), 100 + k);
        end

        // Disabled: count 0, pwm = POL, no tick; same-cycle read/write returns old POL
        set_rd(8'h08, 32'h0);
        cyc(4'b1000, 1'b0, 145);
        set_wr(8'h0C, 32'h1);
        set_rd(8'h0C, 32'h8);
        cyc(4'b1000, 1'b0, 146);
        cyc(4'b0001, 1'b0, 147);

        reset = 1'b1;
        cyc(4'b0001, 1'b0, 148);
        reset = 1'b0;
        cyc(4'b0000, 1'b0, 149);
        cyc(4'b0000, 1'b0, 150);
        rd(8'h00, 32'h0);
        rd(8'h04, 32'h0);
        rd(8'h0C, 32'h0);
        rd(8'h10, 32'h0);
        rd(8'h1C, 32'h0);

        // Center mode: P=8, duty1=2, 16-cycle period
        wr(8'h04, 32'd8);
        wr(8'h14, 32'd2);
        set_wr(8'h00, 32'h3);
        step();
        for (int j = 0; j < 36; j++) begin
            case (j)
                3:  set_rd(8'h08, 32'd3);
                4:  set_rd(8'h08, 32'd4);
                8:  set_rd(8'h08, 32'h8000_0008);
                10: set_rd(8'h08, 32'h8000_0006);
                default: ;
            endcase
            c   = j % 16;
            cnt = (c <= 8) ? c : 16 - c;
            cyc({2'b00, cnt < 2, 1'b0}, (j > 0) && (c == 0), 200 + j);
        end
        step();
        step();

        checks++;
        if (rd_q.size() != 0 || pwm_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations reads=%0d pwm=%0d expected 0 0", rd_q.size(), pwm_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
